// File: rtl/alu_pipe_ctrl.sv
// alu_pipe_ctrl: clocked ALU with valid/ready handshakes on both sides.
// Operands and opcode are taken on in_valid && in_ready. Single-cycle ops
// land in DONE on the accept edge. MUL runs a WIDTH-cycle shift-add in CALC
// first. F and the flags are registered and held while the result waits in
// DONE for out_ready.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  request handshake (in_ready = IDLE && !rst)
//   ALU_OP, A, B         opcode and operands (A[SHW-1:0] is the shift amount)
//   out_valid/out_ready  result handshake
//   F, ZF, OF, CF, SF    registered result and flags
module alu_pipe_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             ZF,
  output logic             OF,
  output logic             CF,
  output logic             SF
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_XNOR = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [2*WIDTH-1:0]   prod_r;     // {partial sum, remaining multiplier bits}
  logic [WIDTH-1:0]     mcand_r;    // latched A for MUL
  logic [SHW-1:0]       cnt_r;      // completed shift-add iterations

  logic                 accept_s;
  logic [SHW-1:0]       shamt_s;
  logic [WIDTH:0]       add_s;
  logic [WIDTH:0]       sub_s;
  logic [WIDTH-1:0]     alu_f_s;
  logic                 alu_of_s;
  logic                 alu_cf_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic                 mul_last_s;

  // Request handshake: depends only on state and reset.
  always_comb begin
    in_ready = (state_r == IDLE) && !rst;
    accept_s = in_valid && in_ready;
  end

  // Single-cycle ALU result and its op-specific flags, straight from the ports.
  always_comb begin
    shamt_s  = A[SHW-1:0];
    add_s    = {1'b0, A} + {1'b0, B};
    // MSB of the widened difference is the unsigned borrow (A < B).
    sub_s    = {1'b0, A} - {1'b0, B};
    alu_f_s  = {WIDTH{1'b0}};
    alu_of_s = 1'b0;
    alu_cf_s = 1'b0;
    case (ALU_OP)
      OP_AND:  alu_f_s = A & B;
      OP_OR:   alu_f_s = A | B;
      OP_XOR:  alu_f_s = A ^ B;
      OP_XNOR: alu_f_s = ~(A ^ B);
      OP_ADD: begin
        alu_f_s  = add_s[WIDTH-1:0];
        alu_cf_s = add_s[WIDTH];
        alu_of_s = (A[WIDTH-1] == B[WIDTH-1]) && (add_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_f_s  = sub_s[WIDTH-1:0];
        alu_cf_s = sub_s[WIDTH];
        alu_of_s = (A[WIDTH-1] != B[WIDTH-1]) && (sub_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  alu_f_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL:  alu_f_s = B << shamt_s;
      OP_SLTU: alu_f_s = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SRL:  alu_f_s = B >> shamt_s;
      OP_SRA:  alu_f_s = $signed(B) >>> shamt_s;
      // MUL is produced by the CALC loop; 12-15 give F=0.
      default: alu_f_s = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add step: add the multiplicand when the current multiplier bit
  // is set, then shift the whole product right by one.
  always_comb begin
    if (prod_r[0]) begin
      mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    end else begin
      mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
    end
    mul_next_s = {mul_sum_s, prod_r[WIDTH-1:1]};
    mul_last_s = (cnt_r == SHW'(WIDTH - 1));
  end

  // Control FSM, multiplier datapath and registered result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      prod_r    <= {(2*WIDTH){1'b0}};
      mcand_r   <= {WIDTH{1'b0}};
      cnt_r     <= {SHW{1'b0}};
      out_valid <= 1'b0;
      F         <= {WIDTH{1'b0}};
      ZF        <= 1'b0;
      OF        <= 1'b0;
      CF        <= 1'b0;
      SF        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (ALU_OP == OP_MUL) begin
              prod_r  <= {{WIDTH{1'b0}}, B};
              mcand_r <= A;
              cnt_r   <= {SHW{1'b0}};
              state_r <= CALC;
            end else begin
              F         <= alu_f_s;
              ZF        <= (alu_f_s == {WIDTH{1'b0}});
              OF        <= alu_of_s;
              CF        <= alu_cf_s;
              SF        <= alu_f_s[WIDTH-1];
              out_valid <= 1'b1;
              state_r   <= DONE;
            end
          end
        end
        CALC: begin
          prod_r <= mul_next_s;
          cnt_r  <= cnt_r + SHW'(1);
          // The last iteration commits the finished product directly.
          if (mul_last_s) begin
            F         <= mul_next_s[WIDTH-1:0];
            ZF        <= (mul_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
            OF        <= |mul_next_s[2*WIDTH-1:WIDTH];
            CF        <= 1'b0;
            SF        <= mul_next_s[WIDTH-1];
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_pipe_ctrl.md
Name: alu_pipe_ctrl

Overview:
Parametrised, clocked successor to the team's combinational 32-bit ALU. It takes operands and an opcode through a valid/ready input handshake and returns a registered result and registered flags through a valid/ready output handshake. It adds arithmetic/logical right shifts, signed/unsigned compare and an iterative multi-cycle multiply. It sits between the operand-select/register-file logic and the writeback/display stage of the lab CPU datapath.

Parameters:
WIDTH, 32, operand/result width; power of 2, minimum 8.
SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  request carries a valid opcode/operands
in_ready  output  1  block can accept a request; equals (state==IDLE && !rst)
ALU_OP  input  4  opcode, sampled on accept
A  input  WIDTH  operand A (shift amount for shifts), sampled on accept
B  input  WIDTH  operand B, sampled on accept
out_valid  output  1  F and flags are valid
out_ready  input  1  consumer takes the result
F  output  WIDTH  result
ZF  output  1  zero flag
OF  output  1  signed overflow (ADD/SUB) or product overflow (MUL)
CF  output  1  carry-out (ADD) or borrow (SUB)
SF  output  1  F[WIDTH-1]

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. While rst is high: state=IDLE, F=0, ZF=0, OF=0, CF=0, SF=0, out_valid=0, in_ready=0. Reset mid-operation aborts silently: no out_valid pulse, and the captured operands are discarded.
- Accept: in_valid && in_ready at a rising edge latches ALU_OP, A and B.
- State machine:
  - IDLE: on accept with ALU_OP != MUL, go to DONE. On accept with MUL, go to CALC.
  - CALC: runs WIDTH cycles of shift-add using a 2*WIDTH product register and a count register. On the last iteration, go to DONE.
  - DONE: out_valid=1. On out_ready=1, go to IDLE.
- Latency and throughput:
  - Non-MUL: out_valid rises on the edge after accept (1 cycle).
  - MUL: out_valid rises WIDTH+1 edges after accept.
  - in_ready is 0 in CALC and DONE, so in_valid in DONE is ignored even when out_ready=1. The earliest next accept is the cycle after DONE exits, giving a maximum of 1 op per 2 cycles.
- Backpressure: in DONE with out_ready=0, F and all flags hold stable indefinitely.
- Opcodes (F is written when entering DONE; flags are computed from that F):
  - 0 AND, 1 OR, 2 XOR, 3 XNOR.
  - 4 ADD: {CF,F}=A+B.
  - 5 SUB: F=A-B; CF=1 iff A<B unsigned.
  - 6 SLT: F=1 if signed A<B, else 0.
  - 7 SLL: F=B<<A[SHW-1:0].
  - 8 SLTU: F=1 if unsigned A<B, else 0.
  - 9 SRL: F=B>>A[SHW-1:0], logical.
  - 10 SRA: F=B>>>A[SHW-1:0], arithmetic (sign-filling).
  - 11 MUL: F=low WIDTH bits of unsigned A*B; OF=1 iff high WIDTH bits are nonzero.
  - 12-15: F=0, all flags 0 except ZF=1.
- Flag rules:
  - OF for ADD: A[W-1]==B[W-1] && F[W-1]!=A[W-1].
  - OF for SUB: A[W-1]!=B[W-1] && F[W-1]!=A[W-1].
  - OF=0 for all ops except ADD, SUB and MUL.
  - CF=0 for all ops except ADD and SUB.
  - ZF=(F==0). SF=F[WIDTH-1] for every op.
- Shift amount: only A[SHW-1:0] is used; upper bits of A are ignored (for WIDTH=32, A=33 shifts by 1).
- Registered outputs: all outputs except in_ready are registered. in_ready is combinational from state and rst only, with no in_valid→in_ready path.

Test Plan:
- WIDTH=32, ADD A=7FFFFFFF B=7FFFFFFF -> one cycle after accept: out_valid=1, F=FFFFFFFE, OF=1, CF=0, SF=1, ZF=0. SUB A=80000000 B=00000001 -> F=7FFFFFFF, OF=1, CF=0.
- SUB A=00000003 B=00000003 -> F=0, ZF=1, CF=0. SUB A=00000003 B=00000607 -> F=FFFFF9FC, CF=1, OF=0, SF=1.
- MUL A=12345678 B=00000010 -> out_valid exactly 33 edges after accept, F=23456780, OF=1. MUL A=0 B=FFFFFFFF -> F=0, ZF=1, OF=0.
- SLT A=FFFFFFFF B=00000001 -> F=1. SLTU with same operands -> F=0. SRA A=00000004 B=80000000 -> F=F8000000. SRL with same operands -> F=08000000. SLL A=00000021 B=00000001 -> F=00000002.
- Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> F and flags unchanged, in_ready=0, no new accept. Raise out_ready -> IDLE next cycle; in_ready=1 and the pending request is accepted on the following edge.
- Assert rst for 1 cycle at the 10th CALC cycle of a MUL -> next edge: out_valid=0, F=0, all flags 0, in_ready=0 during rst and 1 after rst deasserts. No out_valid appears for the aborted MUL.
